// File: rtl/nbody_gravity.sv
// nbody_gravity: N-body gravity engine.
// Keeps N_BODIES positions and velocities in signed fixed point. On each
// frame_tick it integrates every position and applies the edge mode. During
// blanking it then runs one pairwise Manhattan-distance gravity micro-step
// per clock, and each micro-step updates one velocity component.
// Ports:
//   clk, reset                 pixel clock, synchronous active-high reset
//   frame_tick, blanking       timing from hvsync_generator
//   edge_mode                  0 free wrap, 1 screen wrap, 2 bounce, 3 as 0
//   load_* / load_ready        runtime body-state load handshake
//   pos_x_flat, pos_y_flat     integer positions; body k at [k*POS_INT_W +: POS_INT_W]
//   sweep_busy, sweep_done     sweep armed/running, final micro-step pulse
//   overrun                    sticky: frame_tick arrived while sweep_busy
module nbody_gravity #(
  parameter int N_BODIES   = 3,
  parameter int POS_INT_W  = 10,
  parameter int POS_FRAC_W = 3,
  parameter int VEL_W      = 8,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          blanking,
  input  logic [1:0]                    edge_mode,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [2:0]                    load_idx,
  input  logic [POS_INT_W-1:0]          load_px,
  input  logic [POS_INT_W-1:0]          load_py,
  input  logic [VEL_W-1:0]              load_vx,
  input  logic [VEL_W-1:0]              load_vy,
  output logic [N_BODIES*POS_INT_W-1:0] pos_x_flat,
  output logic [N_BODIES*POS_INT_W-1:0] pos_y_flat,
  output logic                          sweep_busy,
  output logic                          sweep_done,
  output logic                          overrun
);

  localparam int POS_W = POS_INT_W + POS_FRAC_W;
  localparam int IDX_W = $clog2(N_BODIES);
  localparam int EXT_W = POS_INT_W + 2;          // signed integer part with headroom
  localparam int SUM_W = EXT_W + POS_FRAC_W;
  localparam int TOTAL = 2 * N_BODIES * (N_BODIES - 1);
  localparam int CNT_W = 8;

  localparam logic signed [EXT_W-1:0] EXT_X  = EXT_W'(SCREEN_W);
  localparam logic signed [EXT_W-1:0] EXT_Y  = EXT_W'(SCREEN_H);
  localparam logic signed [VEL_W:0]   VMAX_E = (VEL_W + 1)'(2 ** (VEL_W - 1) - 1);
  localparam logic signed [VEL_W:0]   VMIN_E = (VEL_W + 1)'(-(2 ** (VEL_W - 1)));

  typedef enum logic [1:0] {IDLE, ARMED, STEP} state_t;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [VEL_W-1:0] vel;
  } axis_t;

  state_t               state;
  logic [POS_W-1:0]     pos_x [N_BODIES];
  logic [POS_W-1:0]     pos_y [N_BODIES];
  logic [VEL_W-1:0]     vel_x [N_BODIES];
  logic [VEL_W-1:0]     vel_y [N_BODIES];
  logic [IDX_W-1:0]     p_idx, q_idx, p_nxt, q_nxt;
  logic                 axis_y;
  logic [CNT_W-1:0]     step_cnt;
  logic                 last_step;
  logic                 load_fire;
  axis_t                int_x [N_BODIES];
  axis_t                int_y [N_BODIES];

  function automatic logic [VEL_W-1:0] neg_sat(input logic [VEL_W-1:0] v);
    if (v == {1'b1, {(VEL_W-1){1'b0}}}) return {1'b0, {(VEL_W-1){1'b1}}};
    return -v;
  endfunction

  // Positions are unsigned screen coordinates. They are zero-extended so that
  // the screen-wrap and bounce tests see the true on-screen value.
  function automatic axis_t integrate(input logic [POS_W-1:0] p,
                                      input logic [VEL_W-1:0] v,
                                      input logic [1:0]       mode,
                                      input logic signed [EXT_W-1:0] ext);
    logic signed [SUM_W-1:0] s;
    logic signed [EXT_W-1:0] ip;
    logic signed [EXT_W-1:0] ip_fix;
    logic signed [EXT_W-1:0] top;
    axis_t r;
    s      = $signed({2'b00, p}) + SUM_W'($signed(v));
    ip     = s[SUM_W-1:POS_FRAC_W];
    top    = ext - {{(EXT_W-1){1'b0}}, 1'b1};
    ip_fix = ip;
    r.pos  = s[POS_W-1:0];
    r.vel  = v;
    case (mode)
      2'd1: begin
        if (ip[EXT_W-1])   ip_fix = ip + ext;
        else if (ip >= ext) ip_fix = ip - ext;
        r.pos = {ip_fix[POS_INT_W-1:0], s[POS_FRAC_W-1:0]};
      end
      2'd2: begin
        if (ip[EXT_W-1]) begin
          r.pos = '0;
          r.vel = neg_sat(v);
        end else if (ip > top) begin
          r.pos = {top[POS_INT_W-1:0], {POS_FRAC_W{1'b0}}};
          r.vel = neg_sat(v);
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < N_BODIES; k++) begin
      int_x[k] = integrate(pos_x[k], vel_x[k], edge_mode, EXT_X);
      int_y[k] = integrate(pos_y[k], vel_y[k], edge_mode, EXT_Y);
    end
  end

  // Gravity micro-step for the current (p, q, axis)
  logic [POS_INT_W-1:0]   px_p, py_p, px_q, py_q;
  logic signed [POS_INT_W:0] dx, dy, d;
  logic [POS_INT_W:0]     adx, ady, man;
  logic [31:0]            man32;
  logic [VEL_W:0]         mag;
  logic signed [VEL_W:0]  dv, vsum;
  logic [VEL_W-1:0]       v_cur, v_new;

  always_comb begin
    px_p  = pos_x[p_idx][POS_W-1:POS_FRAC_W];
    py_p  = pos_y[p_idx][POS_W-1:POS_FRAC_W];
    px_q  = pos_x[q_idx][POS_W-1:POS_FRAC_W];
    py_q  = pos_y[q_idx][POS_W-1:POS_FRAC_W];
    dx    = $signed({1'b0, px_q}) - $signed({1'b0, px_p});
    dy    = $signed({1'b0, py_q}) - $signed({1'b0, py_p});
    adx   = dx[POS_INT_W] ? -dx : dx;
    ady   = dy[POS_INT_W] ? -dy : dy;
    man   = adx + ady;
    man32 = 32'(man);
    if (man32 >= 32'd256)      mag = '0;
    else if (man32 >= 32'd128) mag = (VEL_W + 1)'(2);
    else if (man32 >= 32'd64)  mag = (VEL_W + 1)'(4);
    else                       mag = (VEL_W + 1)'(6);
    d     = axis_y ? dy : dx;
    v_cur = axis_y ? vel_y[p_idx] : vel_x[p_idx];
    if (d == '0)              dv = '0;
    else if (d[POS_INT_W])    dv = -$signed(mag);
    else                      dv = $signed(mag);
    vsum  = $signed({v_cur[VEL_W-1], v_cur}) + dv;
    if (vsum > VMAX_E)        v_new = VMAX_E[VEL_W-1:0];
    else if (vsum < VMIN_E)   v_new = VMIN_E[VEL_W-1:0];
    else                      v_new = vsum[VEL_W-1:0];
  end

  // Next pair in the order p outer, q inner (skipping q == p).
  always_comb begin
    int unsigned nq;
    int unsigned np;
    nq = 32'(q_idx) + 1;
    np = 32'(p_idx);
    if (nq == np) nq = nq + 1;
    if (nq >= N_BODIES) begin
      np = np + 1;
      nq = 0;
    end
    p_nxt = IDX_W'(np);
    q_nxt = IDX_W'(nq);
  end

  assign last_step  = (step_cnt == CNT_W'(TOTAL - 1));
  assign load_ready = !sweep_busy && !frame_tick;
  assign load_fire  = load_valid && load_ready;
  assign sweep_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_BODIES; k++) begin
        pos_x[k] <= {POS_INT_W'((k + 1) * SCREEN_W / (N_BODIES + 1)), {POS_FRAC_W{1'b0}}};
        pos_y[k] <= {POS_INT_W'(SCREEN_H / 2), {POS_FRAC_W{1'b0}}};
        vel_x[k] <= '0;
        vel_y[k] <= '0;
      end
      state      <= IDLE;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;
      p_idx      <= '0;
      q_idx      <= '0;
      axis_y     <= 1'b0;
      step_cnt   <= '0;
    end else begin
      sweep_done <= 1'b0;
      if (frame_tick) begin
        for (int unsigned k = 0; k < N_BODIES; k++) begin
          pos_x[k] <= int_x[k].pos;
          vel_x[k] <= int_x[k].vel;
          pos_y[k] <= int_y[k].pos;
          vel_y[k] <= int_y[k].vel;
        end
        if (sweep_busy) overrun <= 1'b1;
        state    <= ARMED;
        p_idx    <= '0;
        q_idx    <= IDX_W'(1);
        axis_y   <= 1'b0;
        step_cnt <= '0;
      end else begin
        if (load_fire && (32'(load_idx) < N_BODIES)) begin
          pos_x[load_idx[IDX_W-1:0]] <= {load_px, {POS_FRAC_W{1'b0}}};
          pos_y[load_idx[IDX_W-1:0]] <= {load_py, {POS_FRAC_W{1'b0}}};
          vel_x[load_idx[IDX_W-1:0]] <= load_vx;
          vel_y[load_idx[IDX_W-1:0]] <= load_vy;
        end
        case (state)
          ARMED, STEP: begin
            // ARMED performs the first micro-step on the first blanking cycle.
            if (blanking) begin
              if (axis_y) vel_y[p_idx] <= v_new;
              else        vel_x[p_idx] <= v_new;
              if (last_step) begin
                state      <= IDLE;
                sweep_done <= 1'b1;
              end else begin
                state    <= STEP;
                step_cnt <= step_cnt + 1'b1;
                axis_y   <= !axis_y;
                if (axis_y) begin
                  p_idx <= p_nxt;
                  q_idx <= q_nxt;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pos_x_flat = '0;
    pos_y_flat = '0;
    for (int unsigned k = 0; k < N_BODIES; k++) begin
      pos_x_flat[k*POS_INT_W +: POS_INT_W] = pos_x[k][POS_W-1:POS_FRAC_W];
      pos_y_flat[k*POS_INT_W +: POS_INT_W] = pos_y[k][POS_W-1:POS_FRAC_W];
    end
  end

endmodule

// File: tb/tb_nbody_gravity.sv
// tb_nbody_gravity: self-checking bench for nbody_gravity (N=3 defaults).
// It applies table-driven edge-mode vectors, runs hand-written sequences
// for the sweep, load and overrun corners, and then runs random frames that
// are compared against an arithmetic reference model.
module tb_nbody_gravity;
  localparam int N  = 3;
  localparam int PI = 10;
  localparam int PF = 3;
  localparam int VW = 8;
  localparam int SW = 640;
  localparam int SH = 480;

  logic            clk = 1'b0;
  logic            reset, frame_tick, blanking, load_valid, load_ready;
  logic [1:0]      edge_mode;
  logic [2:0]      load_idx;
  logic [PI-1:0]   load_px, load_py;
  logic [VW-1:0]   load_vx, load_vy;
  logic [N*PI-1:0] pos_x_flat, pos_y_flat;
  logic            sweep_busy, sweep_done, overrun;

  always #5 clk = ~clk;

  nbody_gravity #(
    .N_BODIES(N), .POS_INT_W(PI), .POS_FRAC_W(PF), .VEL_W(VW),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .blanking(blanking),
    .edge_mode(edge_mode), .load_valid(load_valid), .load_ready(load_ready),
    .load_idx(load_idx), .load_px(load_px), .load_py(load_py),
    .load_vx(load_vx), .load_vy(load_vy), .pos_x_flat(pos_x_flat),
    .pos_y_flat(pos_y_flat), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .overrun(overrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_x(input int k);
    return int'(pos_x_flat[k*PI +: PI]);
  endfunction
  function automatic int get_y(input int k);
    return int'(pos_y_flat[k*PI +: PI]);
  endfunction

  // Reference model: positions as non-negative fixed-point ints (x8), velocities as ints.
  int mx[N], my[N], mvx[N], mvy[N];

  function automatic void m_reset();
    for (int k = 0; k < N; k++) begin
      mx[k] = ((k + 1) * SW / (N + 1)) * 8;
      my[k] = (SH / 2) * 8;
      mvx[k] = 0;
      mvy[k] = 0;
    end
  endfunction

  function automatic void m_axis(input int p, input int v, input int mode, input int ext,
                                 output int p_o, output int v_o);
    int s, ip, fr;
    s = p + v;
    ip = s >>> 3;
    fr = s & 7;
    v_o = v;
    if (mode == 1) begin
      if (ip < 0) ip = ip + ext;
      else if (ip >= ext) ip = ip - ext;
      s = ip * 8 + fr;
    end else if (mode == 2) begin
      if (ip < 0 || ip > ext - 1) begin
        s = (ip < 0) ? 0 : (ext - 1) * 8;
        v_o = (v == -128) ? 127 : -v;
      end
    end
    p_o = s & 8191;
  endfunction

  function automatic void m_tick(input int mode);
    int p, v;
    for (int k = 0; k < N; k++) begin
      m_axis(mx[k], mvx[k], mode, SW, p, v); mx[k] = p; mvx[k] = v;
      m_axis(my[k], mvy[k], mode, SH, p, v); my[k] = p; mvy[k] = v;
    end
  endfunction

  function automatic int clampv(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic void m_sweep();
    int dx, dy, m, a, d, dv;
    for (int p = 0; p < N; p++)
      for (int q = 0; q < N; q++) begin
        if (q == p) continue;
        dx = (mx[q] >> 3) - (mx[p] >> 3);
        dy = (my[q] >> 3) - (my[p] >> 3);
        m  = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
        a  = (m >= 256) ? 0 : (m >= 128) ? 2 : (m >= 64) ? 4 : 6;
        for (int ax = 0; ax < 2; ax++) begin
          d  = (ax == 0) ? dx : dy;
          dv = (d > 0) ? a : (d < 0) ? -a : 0;
          if (ax == 0) mvx[p] = clampv(mvx[p] + dv);
          else         mvy[p] = clampv(mvy[p] + dv);
        end
      end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_reset();
  endtask

  task automatic load(input int idx, input int px, input int py, input int vx, input int vy);
    load_idx = 3'(idx); load_px = PI'(px); load_py = PI'(py);
    load_vx = VW'(vx); load_vy = VW'(vy);
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    if (idx < N) begin
      mx[idx] = px * 8; my[idx] = py * 8; mvx[idx] = vx; mvy[idx] = vy;
    end
  endtask

  task automatic pulse_tick(input int mode);
    edge_mode = 2'(mode);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 300) begin
      step();
      cyc++;
      if (sweep_done) break;
    end
  endtask

  task automatic cmp_model(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_x%0d", tag, k), get_x(k), (mx[k] >> 3) & 1023);
      check($sformatf("%s_y%0d", tag, k), get_y(k), (my[k] >> 3) & 1023);
    end
  endtask

  typedef struct {
    int idx, mode, px, py, vx, vy, ex1, ey1, ex2, ey2;
  } vec_t;

  vec_t tv[11];

  initial begin
    int c, pulses, early, seen;
    reset = 1'b1; frame_tick = 1'b0; blanking = 1'b0; edge_mode = 2'd0;
    load_valid = 1'b0; load_idx = '0; load_px = '0; load_py = '0;
    load_vx = '0; load_vy = '0;
    step(); step();
    reset = 1'b0;
    m_reset();

    // Reset state
    check("rst_x0", get_x(0), 160); check("rst_x1", get_x(1), 320);
    check("rst_x2", get_x(2), 480); check("rst_y0", get_y(0), 240);
    check("rst_y2", get_y(2), 240); check("rst_ready", load_ready, 1);
    check("rst_busy", sweep_busy, 0); check("rst_done", sweep_done, 0);
    check("rst_ovr", overrun, 0);

    // Edge modes: body 0 after one and two ticks, no sweep (blanking low).
    tv[0]  = '{0, 2, 638, 240,   24,  0, 639, 240, 636, 240};
    tv[1]  = '{0, 1, 638, 240,   24,  0,   1, 240,   4, 240};
    tv[2]  = '{0, 0, 638, 240,   24,  0, 641, 240, 644, 240};
    tv[3]  = '{0, 1,   1, 240,  -24,  0, 638, 240, 635, 240};
    tv[4]  = '{0, 2,   1, 240,  -24,  0,   0, 240,   3, 240};
    tv[5]  = '{0, 2,  10, 240, -128,  0,   0, 240,  15, 240};
    tv[6]  = '{0, 0,   5, 240, -128,  0, 1013, 240, 997, 240};
    tv[7]  = '{0, 3,   5, 240, -128,  0, 1013, 240, 997, 240};
    tv[8]  = '{0, 2, 300, 479,    0,  8, 300, 479, 300, 478};
    tv[9]  = '{0, 1, 300,   2,    0, -24, 300, 479, 300, 476};
    tv[10] = '{5, 0, 600, 100,   40, 40, 160, 240, 160, 240};
    for (int i = 0; i < 11; i++) begin
      do_reset();
      blanking = 1'b0;
      load(tv[i].idx, tv[i].px, tv[i].py, tv[i].vx, tv[i].vy);
      pulse_tick(tv[i].mode);
      check($sformatf("tv%0d_x1", i), get_x(0), tv[i].ex1);
      check($sformatf("tv%0d_y1", i), get_y(0), tv[i].ey1);
      check($sformatf("tv%0d_ovr1", i), overrun, 0);
      step();
      pulse_tick(tv[i].mode);
      check($sformatf("tv%0d_x2", i), get_x(0), tv[i].ex2);
      check($sformatf("tv%0d_y2", i), get_y(0), tv[i].ey2);
      check($sformatf("tv%0d_ovr2", i), overrun, 1);
    end

    // Sweep latency with blanking held high
    do_reset();
    blanking = 1'b1;
    pulse_tick(0); m_tick(0);
    check("lat_busy", sweep_busy, 1);
    wait_done(c);
    check("lat_cycles", c, 12);
    check("lat_busy_after", sweep_busy, 0);
    m_sweep();
    step();
    check("lat_done_1cyc", sweep_done, 0);
    for (int f = 0; f < 8; f++) begin
      pulse_tick(0); m_tick(0);
      cmp_model($sformatf("lat_f%0d", f));
      wait_done(c); m_sweep();
      check("lat_cyc_f", c, 12);
    end

    // Velocity saturation: body 0 pushed toward body 1 with vx=127.
    do_reset();
    blanking = 1'b0;
    load(0, 300, 240, 127, 0);
    pulse_tick(0); m_tick(0);
    check("sat_x0_t1", get_x(0), 315);
    blanking = 1'b1;
    wait_done(c); m_sweep();
    check("sat_cycles", c, 12);
    pulse_tick(0); m_tick(0);
    check("sat_x0_t2", get_x(0), 331);
    check("sat_x1_t2", get_x(1), 319);
    check("sat_x2_t2", get_x(2), 479);
    cmp_model("sat_model");
    wait_done(c); m_sweep();

    // Load held off during a sweep
    do_reset();
    blanking = 1'b0;
    pulse_tick(0); m_tick(0);
    load_idx = 3'd0; load_px = PI'(50); load_py = PI'(60);
    load_vx = '0; load_vy = '0; load_valid = 1'b1;
    check("hold_ready", load_ready, 0);
    repeat (4) step();
    check("hold_x0", get_x(0), 160);
    blanking = 1'b1;
    early = 0; seen = 0; c = 0;
    while (c < 100 && get_x(0) != 50) begin
      step(); c++;
      if (get_x(0) == 50 && seen == 0) early = 1;
      if (sweep_done) seen = 1;
    end
    load_valid = 1'b0;
    m_sweep();
    mx[0] = 50 * 8; my[0] = 60 * 8; mvx[0] = 0; mvy[0] = 0;
    check("hold_early", early, 0);
    check("hold_x0_loaded", get_x(0), 50);
    check("hold_y0_loaded", get_y(0), 60);
    check("hold_ready_after", load_ready, 1);
    load(5, 7, 7, 10, 10);
    cmp_model("idx5");

    // Overrun: stays set, sweep restarts from pair 0
    do_reset();
    blanking = 1'b0;
    pulse_tick(0);
    repeat (3) step();
    check("ovr_before", overrun, 0);
    pulse_tick(0);
    check("ovr_set", overrun, 1);
    blanking = 1'b1;
    wait_done(c);
    check("ovr_restart_cycles", c, 12);
    check("ovr_sticky1", overrun, 1);
    pulse_tick(0);
    wait_done(c);
    check("ovr_sticky2", overrun, 1);
    do_reset();
    check("ovr_cleared", overrun, 0);

    // Reset mid-sweep
    blanking = 1'b1;
    pulse_tick(0);
    repeat (5) step();
    do_reset();
    check("mid_busy", sweep_busy, 0);
    pulses = 0;
    repeat (20) begin step(); if (sweep_done) pulses++; end
    check("mid_no_done", pulses, 0);
    cmp_model("mid_pos");

    // Random frames against the model
    do_reset();
    blanking = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int md, stall;
      if ($urandom_range(0, 1) == 1) begin
        check("rnd_ready", load_ready, 1);
        load($urandom_range(0, 3), $urandom_range(0, SW - 1), $urandom_range(0, SH - 1),
             int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      end
      md = $urandom_range(0, 3);
      stall = $urandom_range(0, 3);
      m_tick(md);
      pulse_tick(md);
      cmp_model($sformatf("rnd%0d", it));
      if (stall != 0) begin
        blanking = 1'b0;
        repeat (stall) step();
        blanking = 1'b1;
      end
      wait_done(c);
      check("rnd_cycles", c, 12);
      m_sweep();
    end
    pulse_tick(0); m_tick(0);
    cmp_model("rnd_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
